// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
//
// Hazard and forwarding controller for a five-stage F/D/E/M/W integer
// pipeline. Sits beside the E stage and produces:
//   - per-operand forwarding mux selects for the E instruction,
//   - a load-use stall when the D instruction reads the register a load in E
//     is about to write,
//   - an MDU stall while a multi-cycle multiply/divide is running and the D
//     instruction needs HI/LO or the MDU itself,
//   - a saturating count of stalled cycles.
//
// Ports:
//   clk          rising-edge clock
//   nrst         synchronous active-low reset
//   src_addr_e   E-stage source register addresses, operand i in slice i
//   src_addr_d   D-stage source register addresses, operand i in slice i
//   src_used_d   per-operand "actually read" flags for the D instruction
//   dst_wen      register-write enable per forwarding stage (bit k-1 = stage k)
//   dst_addr     destination address per forwarding stage (slice k-1 = stage k)
//   dst_addr_e   destination address of the E instruction
//   mem_read_e   E instruction is a load
//   mdu_start_e  E instruction starts a multiply/divide
//   mdu_use_d    D instruction reads HI/LO or starts a multiply/divide
//   mdu_kill     abort the MDU operation in flight
//   fwd_sel      operand select per source: 0 = register file, k = stage k
//   stall_f      hold PC and F/D register
//   stall_d      hold the D instruction
//   flush_e      insert a bubble into E on the next edge
//   mdu_busy     MDU operation in progress
//   stall_cnt    saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_fwd_unit #(
    parameter int ADDR_W  = 5,
    parameter int N_SRC   = 2,
    parameter int N_FWD   = 2,
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic                                     clk,
    input  logic                                     nrst,
    input  logic [N_SRC*ADDR_W-1:0]                  src_addr_e,
    input  logic [N_SRC*ADDR_W-1:0]                  src_addr_d,
    input  logic [N_SRC-1:0]                         src_used_d,
    input  logic [N_FWD-1:0]                         dst_wen,
    input  logic [N_FWD*ADDR_W-1:0]                  dst_addr,
    input  logic [ADDR_W-1:0]                        dst_addr_e,
    input  logic                                     mem_read_e,
    input  logic                                     mdu_start_e,
    input  logic                                     mdu_use_d,
    input  logic                                     mdu_kill,
    output logic [N_SRC*$clog2(N_FWD+1)-1:0]         fwd_sel,
    output logic                                     stall_f,
    output logic                                     stall_d,
    output logic                                     flush_e,
    output logic                                     mdu_busy,
    output logic [CNT_W-1:0]                         stall_cnt
);

    localparam int SEL_W = $clog2(N_FWD + 1);
    localparam logic [7:0] MDU_LAT_C = 8'(MDU_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [7:0]       mdu_cnt_d,   mdu_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    logic [N_SRC*SEL_W-1:0] fwd_sel_c;
    logic                   lu;
    logic                   mh;
    logic                   stall;

    // Forwarding select. Stages are scanned farthest-first so that a match in
    // a nearer stage overwrites it: the nearest producer always wins.
    // Register 0 is hardwired zero and is never forwarded.
    always_comb begin
        fwd_sel_c = '0;
        for (int i = 0; i < N_SRC; i++) begin
            for (int k = N_FWD; k >= 1; k--) begin
                if (dst_wen[k-1] &&
                    (dst_addr[(k-1)*ADDR_W +: ADDR_W] != '0) &&
                    (dst_addr[(k-1)*ADDR_W +: ADDR_W] == src_addr_e[i*ADDR_W +: ADDR_W])) begin
                    fwd_sel_c[i*SEL_W +: SEL_W] = SEL_W'(k);
                end
            end
        end
    end

    assign fwd_sel = fwd_sel_c;

    // Load-use: the loaded value is only available after M, so a dependent
    // D instruction must wait one cycle; forwarding from M covers it after.
    always_comb begin
        lu = 1'b0;
        if (mem_read_e && (dst_addr_e != '0)) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (src_used_d[i] && (src_addr_d[i*ADDR_W +: ADDR_W] == dst_addr_e)) begin
                    lu = 1'b1;
                end
            end
        end
    end

    assign mdu_busy = (mdu_cnt_q != 8'd0);
    assign mh       = mdu_busy && mdu_use_d;
    assign stall    = lu || mh;

    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;

    // MDU busy tracker. Kill beats start and decrement; a start while busy is
    // ignored (the MDU stall keeps a second MDU instruction out of E anyway).
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (mdu_kill) begin
            mdu_cnt_d = 8'd0;
        end else if (mdu_start_e && !mdu_busy) begin
            mdu_cnt_d = MDU_LAT_C;
        end else if (mdu_busy) begin
            mdu_cnt_d = mdu_cnt_q - 8'd1;
        end
    end

    // Saturating stall counter: one increment per stalled cycle even when
    // load-use and MDU hazards coincide.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            mdu_cnt_q   <= 8'd0;
            stall_cnt_q <= '0;
        end else begin
            mdu_cnt_q   <= mdu_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

    localparam int ADDR_W  = 5;
    localparam int N_SRC   = 2;
    localparam int N_FWD   = 2;
    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int SEL_W   = $clog2(N_FWD + 1);

    logic                      clk;
    logic                      nrst;
    logic [N_SRC*ADDR_W-1:0]   src_addr_e;
    logic [N_SRC*ADDR_W-1:0]   src_addr_d;
    logic [N_SRC-1:0]          src_used_d;
    logic [N_FWD-1:0]          dst_wen;
    logic [N_FWD*ADDR_W-1:0]   dst_addr;
    logic [ADDR_W-1:0]         dst_addr_e;
    logic                      mem_read_e;
    logic                      mdu_start_e;
    logic                      mdu_use_d;
    logic                      mdu_kill;
    logic [N_SRC*SEL_W-1:0]    fwd_sel;
    logic                      stall_f;
    logic                      stall_d;
    logic                      flush_e;
    logic                      mdu_busy;
    logic [CNT_W-1:0]          stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    hazard_fwd_unit #(
        .ADDR_W (ADDR_W),
        .N_SRC  (N_SRC),
        .N_FWD  (N_FWD),
        .MDU_LAT(MDU_LAT),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk        (clk),
        .nrst       (nrst),
        .src_addr_e (src_addr_e),
        .src_addr_d (src_addr_d),
        .src_used_d (src_used_d),
        .dst_wen    (dst_wen),
        .dst_addr   (dst_addr),
        .dst_addr_e (dst_addr_e),
        .mem_read_e (mem_read_e),
        .mdu_start_e(mdu_start_e),
        .mdu_use_d  (mdu_use_d),
        .mdu_kill   (mdu_kill),
        .fwd_sel    (fwd_sel),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_e    (flush_e),
        .mdu_busy   (mdu_busy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src_addr_e  = '0;
        src_addr_d  = '0;
        src_used_d  = '0;
        dst_wen     = '0;
        dst_addr    = '0;
        dst_addr_e  = '0;
        mem_read_e  = 1'b0;
        mdu_start_e = 1'b0;
        mdu_use_d   = 1'b0;
        mdu_kill    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        #1;
    endtask

    function automatic logic [31:0] sel_of(input int i);
        return 32'(fwd_sel[i*SEL_W +: SEL_W]);
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        nrst = 1'b0;
        do_reset();

        // Reset state
        check("rst_busy",    32'(mdu_busy),  32'd0);
        check("rst_cnt",     32'(stall_cnt), 32'd0);
        check("rst_stall_f", 32'(stall_f),   32'd0);
        check("rst_stall_d", 32'(stall_d),   32'd0);
        check("rst_flush_e", 32'(flush_e),   32'd0);
        check("rst_fwd_sel", 32'(fwd_sel),   32'd0);

        // Forwarding priority
        dst_wen = 2'b11; dst_addr = {5'd3, 5'd3}; src_addr_e = {5'd0, 5'd3}; #1;
        check("fwd_both_m", sel_of(0), 32'd1);
        dst_wen = 2'b10; #1;
        check("fwd_w_only", sel_of(0), 32'd2);
        dst_wen = 2'b00; #1;
        check("fwd_no_wen", sel_of(0), 32'd0);
        dst_wen = 2'b11; dst_addr = {5'd9, 5'd4}; src_addr_e = {5'd9, 5'd4}; #1;
        check("fwd_op0_m",  sel_of(0), 32'd1);
        check("fwd_op1_w",  sel_of(1), 32'd2);
        dst_addr = {5'd0, 5'd0}; src_addr_e = {5'd0, 5'd0}; #1;
        check("fwd_r0_op0", sel_of(0), 32'd0);
        check("fwd_r0_op1", sel_of(1), 32'd0);
        clear_inputs(); #1;

        // Load-use
        do_reset();
        mem_read_e = 1'b1; dst_addr_e = 5'd7; src_addr_d = {5'd7, 5'd0}; src_used_d = 2'b10; #1;
        check("lu_stall_f", 32'(stall_f), 32'd1);
        check("lu_stall_d", 32'(stall_d), 32'd1);
        check("lu_flush_e", 32'(flush_e), 32'd1);
        check("lu_cnt0",    32'(stall_cnt), 32'd0);
        tick();
        mem_read_e = 1'b0; #1;
        check("lu_released", 32'(stall_d), 32'd0);
        check("lu_cnt1",     32'(stall_cnt), 32'd1);
        mem_read_e = 1'b1; src_used_d = 2'b00; #1;
        check("lu_unused",   32'(stall_d), 32'd0);
        src_used_d = 2'b10; dst_addr_e = 5'd0; src_addr_d = {5'd0, 5'd0}; #1;
        check("lu_r0",       32'(stall_d), 32'd0);
        clear_inputs(); #1;

        // MDU latency
        do_reset();
        mdu_start_e = 1'b1; mdu_use_d = 1'b1; #1;
        check("mdu_c0_busy",  32'(mdu_busy), 32'd0);
        check("mdu_c0_stall", 32'(stall_d),  32'd0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            mdu_start_e = 1'b0; #1;
            check($sformatf("mdu_c%0d_busy", c),  32'(mdu_busy), 32'd1);
            check($sformatf("mdu_c%0d_stall", c), 32'(stall_f),  32'd1);
        end
        tick();
        check("mdu_c5_busy",  32'(mdu_busy),  32'd0);
        check("mdu_c5_stall", 32'(stall_d),   32'd0);
        check("mdu_cnt",      32'(stall_cnt), 32'd4);
        clear_inputs(); #1;

        // MDU kill
        do_reset();
        mdu_start_e = 1'b1; mdu_use_d = 1'b1; #1;
        tick();
        mdu_start_e = 1'b0; #1;
        tick();
        mdu_kill = 1'b1; #1;
        check("kill_c2_busy", 32'(mdu_busy), 32'd1);
        tick();
        mdu_kill = 1'b0; #1;
        check("kill_c3_busy",  32'(mdu_busy),  32'd0);
        check("kill_c3_stall", 32'(stall_d),   32'd0);
        check("kill_cnt",      32'(stall_cnt), 32'd2);
        clear_inputs(); #1;

        // Reset mid-operation
        do_reset();
        mdu_start_e = 1'b1; mdu_use_d = 1'b1; #1;
        tick();
        mdu_start_e = 1'b0; #1;
        tick();
        check("rmid_c2_busy", 32'(mdu_busy), 32'd1);
        nrst = 1'b0;
        tick();
        nrst = 1'b1; #1;
        check("rmid_busy",    32'(mdu_busy),  32'd0);
        check("rmid_cnt",     32'(stall_cnt), 32'd0);
        check("rmid_stall_f", 32'(stall_f),   32'd0);
        check("rmid_flush_e", 32'(flush_e),   32'd0);
        clear_inputs(); #1;

        // Simultaneous load-use and MDU hazard: one increment per cycle
        do_reset();
        mdu_start_e = 1'b1; #1;
        tick();
        mdu_start_e = 1'b0; mdu_use_d = 1'b1;
        mem_read_e = 1'b1; dst_addr_e = 5'd6; src_addr_d = {5'd0, 5'd6}; src_used_d = 2'b01; #1;
        check("both_stall", 32'(stall_d), 32'd1);
        tick();
        check("both_cnt", 32'(stall_cnt), 32'd1);
        clear_inputs(); #1;

        // Saturation
        do_reset();
        mem_read_e = 1'b1; dst_addr_e = 5'd5; src_addr_d = {5'd0, 5'd5}; src_used_d = 2'b01; #1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 14) check("sat_14", 32'(stall_cnt), 32'd14);
            if (n == 15) check("sat_15", 32'(stall_cnt), 32'd15);
        end
        check("sat_20", 32'(stall_cnt), 32'd15);
        clear_inputs(); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
